// File: rtl/sram_like_mem_pkg.sv
// Shared types and helpers for sram_like_mem: size encodings, lane enables,
// alignment check and the response pipeline payload.
package sram_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int unsigned DATA_W = 32;
    // Channel id field is sized for the largest supported channel count (8).
    localparam int unsigned ID_W   = 3;

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } rsp_t;

    // Byte lanes touched by an access; size 11 behaves as a word.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: byte_en = 4'b0001 << addr_lo;
            SIZE_HALF: byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   byte_en = 4'b1111;
        endcase
    endfunction

    // Half needs even address, word needs 4-byte alignment.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = addr_lo[0];
            default:   misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/sram_like_mem_arbiter.sv
// Single-grant arbiter for sram_like_mem.
// SRAM_ARB_RR_EN defined: round-robin after the last-granted channel.
// SRAM_ARB_RR_EN undefined: fixed priority, lowest index wins, no state.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

`ifdef SRAM_ARB_RR_EN
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [N-1:0]  hi_mask;
    logic [N-1:0]  req_hi;

    // Prefer the lowest requester above the pointer, else wrap to the lowest overall
    always_comb begin
        hi_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            hi_mask[i] = (PW'(i) > ptr);
        end
        req_hi = req & hi_mask;
        if (req_hi != '0) begin
            grant = req_hi & (~req_hi + N'(1));
        end else begin
            grant = req & (~req + N'(1));
        end
    end

    // Remember the last-granted channel; reset so channel 0 wins first
    always_ff @(posedge clk) begin
        if (rstn) begin
            ptr <= PW'(N - 1);
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (grant[i]) begin
                    ptr <= PW'(i);
                end
            end
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rstn;

    // Isolate the lowest set request bit
    always_comb begin
        grant = req & (~req + N'(1));
    end
`endif

endmodule

// File: rtl/sram_like_mem.sv
// Multi-channel SRAM-like memory: one shared word array, one accept per cycle,
// lane-enabled writes, LAT-deep response pipeline and a sticky misalignment flag.
// Arbitration mode is selected by SRAM_ARB_RR_EN (see rr_arbiter).
module sram_like_mem
    import sram_pkg::*;
#(
    parameter int unsigned NCH    = 2,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NCH-1:0]        req,
    input  logic [NCH-1:0]        wr,
    input  logic [2*NCH-1:0]      size,
    input  logic [ADDR_W*NCH-1:0] addr,
    input  logic [32*NCH-1:0]     wdata,
    output logic [NCH-1:0]        addr_ok,
    output logic [NCH-1:0]        data_ok,
    output logic [32*NCH-1:0]     rdata,
    output logic                  err
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned WORDS = 1 << IDX_W;

    logic [31:0]       mem [WORDS];
    logic [NCH-1:0]    grant;
    logic              acc;
    logic [ID_W-1:0]   sel_id;
    logic              sel_wr;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [IDX_W-1:0]  sel_idx;
    logic [3:0]        sel_be;
    logic              sel_mis;
    rsp_t              new_rsp;
    rsp_t              link [LAT];
    rsp_t              last;

    rr_arbiter #(.N(NCH)) u_arb (
        .clk   (clk),
        .rstn  (rstn),
        .req   (req),
        .grant (grant)
    );

    assign addr_ok = grant & req & {NCH{~rstn}};

    // Mux the granted channel's request fields
    always_comb begin
        acc       = |addr_ok;
        sel_id    = '0;
        sel_wr    = 1'b0;
        sel_size  = SIZE_WORD;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (addr_ok[i]) begin
                sel_id    = ID_W'(i);
                sel_wr    = wr[i];
                sel_size  = size[2*i +: 2];
                sel_addr  = addr[ADDR_W*i +: ADDR_W];
                sel_wdata = wdata[32*i +: 32];
            end
        end
    end

    assign sel_idx = sel_addr[ADDR_W-1:2];
    assign sel_be  = byte_en(sel_size, sel_addr[1:0]);
    assign sel_mis = misaligned(sel_size, sel_addr[1:0]);

    // Lane-enabled write on the accept edge; misaligned writes are dropped
    always_ff @(posedge clk) begin
        if (acc && sel_wr && !sel_mis) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (sel_be[k]) begin
                    mem[sel_idx][8*k +: 8] <= sel_wdata[8*k +: 8];
                end
            end
        end
    end

    // Response entering the pipeline: read word, or zero for writes/misaligned
    always_comb begin
        new_rsp.valid = acc;
        new_rsp.id    = sel_id;
        new_rsp.data  = (sel_wr || sel_mis) ? '0 : mem[sel_idx];
    end

    assign link[0] = new_rsp;

    generate
        if (LAT > 1) begin : g_pipe
            rsp_t stage [LAT-1];

            // Delay stages between accept and the output registers
            always_ff @(posedge clk) begin
                for (int unsigned i = 0; i < LAT - 1; i++) begin
                    if (rstn) begin
                        stage[i] <= '0;
                    end else begin
                        stage[i] <= link[i];
                    end
                end
            end

            for (genvar i = 1; i < LAT; i++) begin : g_link
                assign link[i] = stage[i-1];
            end
        end
    endgenerate

    assign last = link[LAT-1];

    // Output stage: one-cycle data_ok pulse, addressed rdata slice updated
    always_ff @(posedge clk) begin
        if (rstn) begin
            data_ok <= '0;
            rdata   <= '0;
        end else begin
            data_ok <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (last.valid && last.id == ID_W'(i)) begin
                    data_ok[i]        <= 1'b1;
                    rdata[32*i +: 32] <= last.data;
                end
            end
        end
    end

    // Sticky misaligned-access flag
    always_ff @(posedge clk) begin
        if (rstn) begin
            err <= 1'b0;
        end else if (acc && sel_mis) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_like_mem.sv
// Directed bench for sram_like_mem with a scoreboard of expected responses.
module tb_sram_like_mem;

    localparam int unsigned NCH    = 2;
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned LAT    = 2;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [NCH-1:0]        req;
    logic [NCH-1:0]        wr;
    logic [2*NCH-1:0]      size;
    logic [ADDR_W*NCH-1:0] addr;
    logic [32*NCH-1:0]     wdata;
    logic [NCH-1:0]        addr_ok;
    logic [NCH-1:0]        data_ok;
    logic [32*NCH-1:0]     rdata;
    logic                  err;

    sram_like_mem #(.NCH(NCH), .ADDR_W(ADDR_W), .LAT(LAT)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .addr    (addr),
        .wdata   (wdata),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model [int];
    logic [31:0] exp_rdata [NCH];
    logic        exp_err;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    // Count a check and report a failure
    task automatic report(input string tag, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s", tag);
        end
    endtask

    // Checks responses, rdata hold, err, and records accepts into the model
    task automatic monitor();
        exp_t           e;
        logic [NCH-1:0] onehot;
        int             idx;
        int             l;
        logic [1:0]     sz;
        logic [ADDR_W-1:0] a;
        logic [31:0]    wd;
        logic [31:0]    old;
        logic           mis;
        forever begin
            @(negedge clk);
            cyc++;
            if (data_ok !== '0) begin
                if (sb.size() == 0) begin
                    report("unexpected_data_ok", data_ok === {NCH{1'b0}});
                end else begin
                    e = sb.pop_front();
                    onehot = '0;
                    onehot[e.ch] = 1'b1;
                    report("rsp_channel", data_ok === onehot);
                    report("rsp_cycle", cyc === e.due);
                    report("rsp_rdata", rdata[32*e.ch +: 32] === e.data);
                    exp_rdata[e.ch] = e.data;
                end
            end else if (sb.size() != 0 && sb[0].due < cyc) begin
                report("rsp_missing", cyc === sb[0].due);
                void'(sb.pop_front());
            end
            if (rstn === 1'b0) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    report("rdata_hold", rdata[32*ch +: 32] === exp_rdata[ch]);
                end
                report("err_flag", err === exp_err);
                report("single_grant", $onehot0(addr_ok) === 1'b1);
                for (int ch = 0; ch < NCH; ch++) begin
                    if (req[ch] && addr_ok[ch]) begin
                        sz  = size[2*ch +: 2];
                        a   = addr[ADDR_W*ch +: ADDR_W];
                        wd  = wdata[32*ch +: 32];
                        idx = int'(a >> 2);
                        l   = int'(a[1:0]);
                        mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
                        if (mis) exp_err = 1'b1;
                        if (wr[ch]) begin
                            if (!mis) begin
                                old = model.exists(idx) ? model[idx] : 32'hx;
                                if (sz == 2'b00) old[8*l +: 8] = wd[8*l +: 8];
                                else if (sz == 2'b01) old[16*(l/2) +: 16] = wd[16*(l/2) +: 16];
                                else old = wd;
                                model[idx] = old;
                            end
                            sb.push_back('{ch: ch, data: 32'h0, due: cyc + LAT});
                        end else begin
                            sb.push_back('{ch: ch, data: mis ? 32'h0 : model[idx], due: cyc + LAT});
                        end
                    end
                end
            end else begin
                report("addr_ok_in_reset", addr_ok === {NCH{1'b0}});
                sb.delete();
                exp_err = 1'b0;
                for (int ch = 0; ch < NCH; ch++) exp_rdata[ch] = 32'h0;
            end
        end
    endtask

    // Present one request on a channel and hold it until accepted
    task automatic access(input int ch, input logic w, input logic [1:0] sz,
                          input logic [ADDR_W-1:0] a, input logic [31:0] d);
        bit got = 1'b0;
        req[ch] = 1'b1;
        wr[ch] = w;
        size[2*ch +: 2] = sz;
        addr[ADDR_W*ch +: ADDR_W] = a;
        wdata[32*ch +: 32] = d;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (addr_ok[ch]) got = 1'b1;
            @(posedge clk);
            #2;
        end
        req[ch] = 1'b0;
        report("accept_timeout", got === 1'b1);
    endtask

    task automatic wait_idle();
        repeat (LAT + 2) @(posedge clk);
        #2;
    endtask

    logic [NCH-1:0] cont_exp [4];
    bit             got1;

    initial begin
        rstn = 1'b1;
        req = '0; wr = '0; size = '0; addr = '0; wdata = '0;
        exp_err = 1'b0;
        for (int ch = 0; ch < NCH; ch++) exp_rdata[ch] = 32'h0;
`ifdef SRAM_ARB_RR_EN
        cont_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        cont_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation did not complete");
                $fatal(1);
            end
        join_none

        // Reset values, and no accept while reset is asserted
        repeat (2) @(posedge clk);
        #2;
        req = '1;
        @(negedge clk);
        report("reset_addr_ok", addr_ok === 2'b00);
        report("reset_data_ok", data_ok === 2'b00);
        report("reset_rdata", rdata === 64'h0);
        report("reset_err", err === 1'b0);
        @(posedge clk);
        #2;
        req = '0;
        rstn = 1'b0;

        // Basic word write then read on channel 1
        access(1, 1'b1, 2'b10, 17'h100, 32'hDEADBEEF);
        access(1, 1'b0, 2'b10, 17'h100, 32'h0);
        wait_idle();
        report("basic_read", rdata[63:32] === 32'hDEADBEEF);

        // Byte write into lane 2, then halfword write into the upper half
        access(1, 1'b1, 2'b00, 17'h102, 32'h00AA0000);
        access(1, 1'b0, 2'b10, 17'h100, 32'h0);
        wait_idle();
        report("byte_write", rdata[63:32] === 32'hDEAABEEF);
        access(0, 1'b1, 2'b01, 17'h102, 32'h12340000);
        access(0, 1'b0, 2'b10, 17'h100, 32'h0);
        wait_idle();
        report("half_write", rdata[31:0] === 32'h1234BEEF);
        report("other_slice_hold", rdata[63:32] === 32'hDEAABEEF);

        // Contention: last grant was channel 1, both request for 4 cycles
        access(1, 1'b0, 2'b10, 17'h100, 32'h0);
        req = 2'b11; wr = 2'b00; size = 4'b1010;
        addr = {17'h100, 17'h100};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            report("contention_grant", addr_ok === cont_exp[k]);
            @(posedge clk);
            #2;
        end
        req = '0;
        wait_idle();

        // Misaligned word read, suppressed misaligned half write, aligned write
        access(0, 1'b0, 2'b10, 17'h101, 32'h0);
        wait_idle();
        report("mis_rdata", rdata[31:0] === 32'h0);
        report("mis_err", err === 1'b1);
        access(0, 1'b1, 2'b01, 17'h103, 32'hFFFF0000);
        access(0, 1'b1, 2'b10, 17'h104, 32'hCAFEF00D);
        access(0, 1'b0, 2'b10, 17'h104, 32'h0);
        wait_idle();
        report("aligned_after_mis", rdata[31:0] === 32'hCAFEF00D);
        access(0, 1'b0, 2'b10, 17'h100, 32'h0);
        wait_idle();
        report("mis_write_suppressed", rdata[31:0] === 32'h1234BEEF);
        report("err_sticky", err === 1'b1);

        // Back-to-back writes then reads on channel 0
        req[0] = 1'b1; wr[0] = 1'b1; size[1:0] = 2'b10;
        for (int i = 0; i < 8; i++) begin
            addr[16:0] = 17'(32'h200 + 4 * i);
            wdata[31:0] = 32'hA5000000 | 32'(i);
            @(negedge clk);
            report("b2b_write_accept", addr_ok[0] === 1'b1);
            @(posedge clk);
            #2;
        end
        wr[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            addr[16:0] = 17'(32'h200 + 4 * i);
            @(negedge clk);
            report("b2b_read_accept", addr_ok[0] === 1'b1);
            @(posedge clk);
            #2;
        end
        req[0] = 1'b0;
        wait_idle();
        report("b2b_last_rdata", rdata[31:0] === 32'hA5000007);

        // Reset right after a read accept: response dropped, prior write kept
        access(0, 1'b1, 2'b10, 17'h300, 32'h5A5A1234);
        access(0, 1'b0, 2'b10, 17'h100, 32'h0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #2;
        report("post_reset_err", err === 1'b0);
        req = 2'b11; wr = 2'b00; size = 4'b1010;
        addr = {17'h300, 17'h300};
        @(negedge clk);
        report("post_reset_first_grant", addr_ok === 2'b01);
        @(posedge clk);
        #2;
        req[0] = 1'b0;
        got1 = 1'b0;
        for (int n = 0; n < 20 && !got1; n++) begin
            @(negedge clk);
            if (addr_ok[1]) got1 = 1'b1;
            @(posedge clk);
            #2;
        end
        req = '0;
        report("post_reset_ch1_accept", got1 === 1'b1);
        wait_idle();
        report("reset_keeps_write", rdata[63:32] === 32'h5A5A1234);
        report("reset_keeps_write_ch0", rdata[31:0] === 32'h5A5A1234);

        wait_idle();
        report("scoreboard_drained", sb.size() === 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
